// File: rtl/serial_adder_seq.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_seq
// Description : Bit-serial WIDTH-bit unsigned adder, LSB first, one bit/clock.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int              CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;

    logic             w_bit_sum;
    logic             w_carry_next;
    logic [WIDTH-1:0] w_sum_next;

    // 1-bit full-adder cell on the current LSBs and the registered carry
    assign w_bit_sum    = r_a_sr[0] ^ r_b_sr[0] ^ r_carry;
    assign w_carry_next = (r_a_sr[0] & r_b_sr[0]) | (r_a_sr[0] & r_carry) |
                          (r_b_sr[0] & r_carry);

    generate
        if (WIDTH == 1) begin : g_sum_w1
            assign w_sum_next = w_bit_sum;
        end else begin : g_sum_wn
            assign w_sum_next = {w_bit_sum, sum[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a_sr  <= a;
                        r_b_sr  <= b;
                        r_carry <= 1'b0;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= SHIFT;
                    end else begin
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                SHIFT: begin
                    r_a_sr  <= r_a_sr >> 1;
                    r_b_sr  <= r_b_sr >> 1;
                    r_carry <= w_carry_next;
                    sum     <= w_sum_next;
                    r_cnt   <= r_cnt + 1'b1;
                    // Final bit: carry-out is the carry leaving the MSB position
                    if (r_cnt == C_LAST) begin
                        cout    <= w_carry_next;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= DONE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder_seq
// Description : Self-checking bench for serial_adder_seq at WIDTH=8 and WIDTH=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder_seq;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, sum8;
    logic       busy8, done8, cout8;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0, sum4;
    logic       busy4, done4, cout4;

    serial_adder_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] sum;
        logic       cout;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Start an 8-bit add, scramble operands while it runs, return result and timing
    task automatic op8(input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] s, output logic c,
                       output int lat, output int bcnt);
        @(negedge clk);
        start8 = 1'b1; a8 = a; b8 = b;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = ~a; b8 = 8'($urandom);
        lat = 0; bcnt = 0;
        while (done8 !== 1'b1 && lat < 20) begin
            if (busy8) bcnt++;
            @(posedge clk); #1;
            lat++;
            a8 = 8'($urandom);
        end
        s = sum8; c = cout8;
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b,
                       output logic [3:0] s, output logic c, output int lat);
        @(negedge clk);
        start4 = 1'b1; a4 = a; b4 = b;
        @(posedge clk); #1;
        start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
        lat = 0;
        while (done4 !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        s = sum4; c = cout4;
    endtask

    initial begin
        logic [7:0] s8;
        logic [3:0] s4;
        logic       c;
        int         lat, bcnt, nd;
        logic [8:0] exp9;
        logic [4:0] exp5;

        vecs[0] = '{a: 8'h00, b: 8'h00, sum: 8'h00, cout: 1'b0};
        vecs[1] = '{a: 8'hA5, b: 8'h5A, sum: 8'hFF, cout: 1'b0};
        vecs[2] = '{a: 8'hFF, b: 8'h01, sum: 8'h00, cout: 1'b1};
        vecs[3] = '{a: 8'hFF, b: 8'hFF, sum: 8'hFE, cout: 1'b1};

        // Reset, then idle
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {busy8, done8, cout8, sum8}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("idle_outputs", {busy8, done8, cout8, sum8}, 32'h0);
        end

        // Directed table
        for (int i = 0; i < 4; i++) begin
            op8(vecs[i].a, vecs[i].b, s8, c, lat, bcnt);
            check("dir_latency", lat, 8);
            check("dir_busy_cycles", bcnt, 8);
            check("dir_sum", s8, vecs[i].sum);
            check("dir_cout", c, vecs[i].cout);
            @(posedge clk); #1;
            check("dir_done_one_cycle", done8, 1'b0);
            repeat (3) @(posedge clk);
            #1;
            check("dir_hold", {cout8, sum8}, {vecs[i].cout, vecs[i].sum});
        end

        // Randomised against plain arithmetic
        for (int i = 0; i < 40; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom); rb = 8'($urandom);
            exp9 = {1'b0, ra} + {1'b0, rb};
            op8(ra, rb, s8, c, lat, bcnt);
            check("rand_result", {c, s8}, exp9);
            check("rand_latency", lat, 8);
        end

        // Start during busy plus operand churn: only one result, from first operands
        repeat (2) @(posedge clk);
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h12; b8 = 8'h34;
        @(posedge clk); #1;
        start8 = 1'b0;
        nd = 0; s8 = '0; c = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            a8 = 8'($urandom); b8 = 8'($urandom);
            start8 = (i == 2);
            if (i == 2) begin a8 = 8'hFF; b8 = 8'hFF; end
            @(posedge clk); #1;
            if (done8) begin nd++; s8 = sum8; c = cout8; end
        end
        start8 = 1'b0;
        check("busy_start_done_count", nd, 1);
        check("busy_start_sum", s8, 8'h46);
        check("busy_start_cout", c, 1'b0);

        // Back-to-back: start held during the DONE cycle
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h80; b8 = 8'h80;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = 0;
        while (done8 !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
        check("b2b_first_latency", lat, 8);
        check("b2b_first_result", {cout8, sum8}, 9'h100);
        start8 = 1'b1; a8 = 8'h01; b8 = 8'h02;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'($urandom);
        lat = 1;
        while (done8 !== 1'b1 && lat < 30) begin @(posedge clk); #1; lat++; end
        check("b2b_second_spacing", lat, 9);
        check("b2b_second_result", {cout8, sum8}, 9'h003);

        // Asynchronous reset mid-operation
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h7F; b8 = 8'h01;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid_op_busy_before_reset", busy8, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_immediate", {busy8, done8, cout8, sum8}, 32'h0);
        nd = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (done8) nd++;
        end
        check("reset_no_done", nd, 0);
        @(negedge clk);
        rst_n = 1'b1;
        op8(8'h0F, 8'h01, s8, c, lat, bcnt);
        check("post_reset_result", {c, s8}, 9'h010);
        check("post_reset_latency", lat, 8);

        // Exhaustive WIDTH=4
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                exp5 = 5'(ia) + 5'(ib);
                op4(4'(ia), 4'(ib), s4, c, lat);
                check("w4_result", {c, s4}, exp5);
                check("w4_latency", lat, 4);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
